// File: rtl/noc_pkg.sv
// Shared types, packet field layout and small helpers for the NoC packetizer.
package noc_pkg;

    localparam int PKT_W     = 13;
    localparam int PAYLOAD_W = 8;

    localparam int TYPE_MSB = 12;
    localparam int TYPE_LSB = 11;
    localparam int EOF_BIT  = 10;
    localparam int SEQ_MSB  = 9;
    localparam int SEQ_LSB  = 8;

    typedef enum logic [1:0] {
        PKT_DATA = 2'b00,
        PKT_CTRL = 2'b01,
        PKT_RESP = 2'b10
    } pkt_type_e;

    typedef enum logic {
        PZ_IDLE  = 1'b0,
        PZ_BURST = 1'b1
    } pz_state_e;

    // Channel order is data -> ctrl -> resp -> data.
    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        case (ch)
            2'd0:    next_ch = 2'd1;
            2'd1:    next_ch = 2'd2;
            default: next_ch = 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] onehot_to_ch(input logic [2:0] oh);
        if (oh[1])      onehot_to_ch = 2'd1;
        else if (oh[2]) onehot_to_ch = 2'd2;
        else            onehot_to_ch = 2'd0;
    endfunction

    function automatic logic [PKT_W-1:0] make_pkt(
        input pkt_type_e            t,
        input logic                 eof,
        input logic [1:0]           seq,
        input logic [PAYLOAD_W-1:0] payload
    );
        logic [PKT_W-1:0] p;
        p                    = '0;
        p[TYPE_MSB:TYPE_LSB] = t;
        p[EOF_BIT]           = eof;
        p[SEQ_MSB:SEQ_LSB]   = seq;
        p[PAYLOAD_W-1:0]     = payload;
        return p;
    endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Three-way round-robin arbiter; the pointer moves past the winner only on advance_i.
module noc_rr_arbiter
    import noc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req_i,
    input  logic       advance_i,
    input  logic [1:0] winner_i,
    output logic [2:0] grant_o
);

    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        grant_o = '0;
        idx     = ptr_q;
        found   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
            idx = next_ch(idx);
        end
    end

    assign ptr_d = advance_i ? next_ch(winner_i) : ptr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/noc_packetizer.sv
// Packs three byte channels into 13-bit router packets, frame-granular round-robin.
// Optional mid-frame stall timeout is enabled with NOC_PKT_TIMEOUT_EN.
//
// state    | meaning
// PZ_IDLE  | no frame open; pick next channel from the arbiter
// PZ_BURST | frame open on ch_q; forward its beats until last (or timeout)
module noc_packetizer
    import noc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data_in,
    input  logic             data_last,
    input  logic             data_in_valid,
    output logic             data_in_ready,
    input  logic [7:0]       ctrl_in,
    input  logic             ctrl_last,
    input  logic             ctrl_in_valid,
    output logic             ctrl_in_ready,
    input  logic [7:0]       resp_in,
    input  logic             resp_last,
    input  logic             resp_in_valid,
    output logic             resp_in_ready,
    output logic [PKT_W-1:0] packet,
    output logic             src_valid,
    input  logic             src_ready,
    output logic             err_timeout
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_param_chk
        $error("noc_packetizer: TIMEOUT_CYCLES must be within 2..255");
    end

    pz_state_e        state_q;
    logic [1:0]       ch_q;
    logic [PKT_W-1:0] pkt_q;
    logic             vld_q;
    logic [2:0][1:0]  seq_q;

    logic [2:0]           req;
    logic [2:0]           grant;
    logic                 sel_valid;
    logic                 sel_last;
    logic [PAYLOAD_W-1:0] sel_data;
    logic                 out_free;
    logic                 burst_rdy;
    logic                 in_hs;
    logic                 tmo_fire;
    logic                 frame_end;

    assign req = {resp_in_valid, ctrl_in_valid, data_in_valid};

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        case (ch_q)
            2'd0: begin
                sel_valid = data_in_valid;
                sel_last  = data_last;
                sel_data  = data_in;
            end
            2'd1: begin
                sel_valid = ctrl_in_valid;
                sel_last  = ctrl_last;
                sel_data  = ctrl_in;
            end
            2'd2: begin
                sel_valid = resp_in_valid;
                sel_last  = resp_last;
                sel_data  = resp_in;
            end
            default: ;
        endcase
    end

    // Output register accepts a new beat when empty or being drained this cycle.
    assign out_free  = ~vld_q | src_ready;
    assign burst_rdy = (state_q == PZ_BURST) & out_free;
    assign in_hs     = burst_rdy & sel_valid;
    assign frame_end = (in_hs & sel_last) | tmo_fire;

    assign data_in_ready = burst_rdy & (ch_q == 2'd0);
    assign ctrl_in_ready = burst_rdy & (ch_q == 2'd1);
    assign resp_in_ready = burst_rdy & (ch_q == 2'd2);

    assign packet    = pkt_q;
    assign src_valid = vld_q;

    noc_rr_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .advance_i (frame_end),
        .winner_i  (ch_q),
        .grant_o   (grant)
    );

`ifdef NOC_PKT_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_q;
    logic       err_q;

    // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle, once the output slot is free.
    assign tmo_fire    = (state_q == PZ_BURST) & ~sel_valid & out_free & (tmo_cnt_q >= TMO_LAST);
    assign err_timeout = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= tmo_fire;
            if (state_q != PZ_BURST || in_hs || tmo_fire) begin
                tmo_cnt_q <= '0;
            end else if (!sel_valid && tmo_cnt_q < TMO_LAST) begin
                tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end
        end
    end
`else
    assign tmo_fire    = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PZ_IDLE;
            ch_q    <= 2'd0;
            pkt_q   <= '0;
            vld_q   <= 1'b0;
            seq_q   <= '0;
        end else begin
            if (src_ready) begin
                vld_q <= 1'b0;
            end
            case (state_q)
                PZ_IDLE: begin
                    if (|req) begin
                        ch_q    <= onehot_to_ch(grant);
                        state_q <= PZ_BURST;
                    end
                end
                PZ_BURST: begin
                    if (in_hs) begin
                        pkt_q <= make_pkt(pkt_type_e'(ch_q), sel_last, seq_q[ch_q], sel_data);
                        vld_q <= 1'b1;
                    end else if (tmo_fire) begin
                        pkt_q <= make_pkt(pkt_type_e'(ch_q), 1'b1, seq_q[ch_q], 8'hFF);
                        vld_q <= 1'b1;
                    end
                    if (frame_end) begin
                        seq_q[ch_q] <= seq_q[ch_q] + 2'd1;
                        state_q     <= PZ_IDLE;
                    end
                end
                default: state_q <= PZ_IDLE;
            endcase
        end
    end

endmodule

// File: doc/noc_packetizer.md
Name: noc_packetizer

Overview:
- Transmit end of the 13-bit router packet interface: packs three 8-bit source channels (data, ctrl, resp) into packets on `packet`/`src_valid`/`src_ready`, the same interface the router consumes.
- Arbitrates round-robin between channels at frame granularity. A frame is never interleaved with another.
- Adds the type, end-of-frame flag and a per-channel 2-bit frame sequence number to every packet.

Parameters:
- TIMEOUT_CYCLES, 16, mid-frame stall limit in cycles (used only with NOC_PKT_TIMEOUT_EN); legal range 2..255.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- data_in  in  8  data channel payload
- data_last  in  1  data channel end-of-frame beat
- data_in_valid  in  1  data channel valid
- data_in_ready  out  1  data channel ready
- ctrl_in, ctrl_last, ctrl_in_valid, ctrl_in_ready  in/in/in/out  8/1/1/1  ctrl channel, same meaning as data channel
- resp_in, resp_last, resp_in_valid, resp_in_ready  in/in/in/out  8/1/1/1  resp channel, same meaning as data channel
- packet  out  13  packet to router
- src_valid  out  1  packet valid
- src_ready  in  1  router ready
- err_timeout  out  1  one-cycle pulse on forced frame close

Behaviour:
- Packet format:
  - [12:11] type: 00 data, 01 ctrl, 10 resp; 11 is reserved and never driven.
  - [10] eof.
  - [9:8] seq.
  - [7:0] payload.
- Reset (rst=0, asynchronous):
  - src_valid=0, packet=0, all *_in_ready=0, err_timeout=0.
  - FSM goes to IDLE; round-robin pointer points to data; all seq counters 0.
  - A partial frame is dropped. Reset mid-frame gives no eof packet.
- FSM IDLE:
  - If any *_in_valid is high, register a grant to the first valid channel at or after the RR pointer (order data→ctrl→resp→data) and go to BURST.
  - All ready outputs stay 0 in IDLE.
- FSM BURST:
  - Granted channel ready = ~src_valid | src_ready. Non-granted readies = 0.
  - On an input handshake, the output register loads {type, last, seq[ch], payload] and src_valid=1.
- Output register:
  - packet and src_valid hold stable while src_valid & ~src_ready.
  - src_valid clears when src_ready is high and no new beat is loaded.
  - Full throughput is one beat per cycle with src_ready held high.
- End of frame (handshake with last=1):
  - seq[ch] increments mod 4.
  - RR pointer moves to the channel after the winner.
  - FSM returns to IDLE. This gives one bubble cycle between frames.
- Latency: first beat of a frame appears on src_valid 2 cycles after *_in_valid rises in IDLE.
- Other valid channels are ignored until the current frame closes. A channel that drops valid mid-frame stays granted.
- Single-beat frames (last=1 on the first beat) are legal.
- Simultaneous valid on all three channels, starting from reset: frames are served data, ctrl, resp, data, …

Optional Feature:
- Macro: NOC_PKT_TIMEOUT_EN.
- Defined:
  - In BURST, a counter increments each cycle the granted channel's valid is low. It clears on any granted handshake.
  - When it reaches TIMEOUT_CYCLES and the output register is free, the block injects {type=ch, eof=1, seq[ch], payload=8'hFF}.
  - It then pulses err_timeout for one cycle, increments seq[ch], advances the RR pointer and goes to IDLE.
- Undefined: no counter; err_timeout is tied to 0; a stalled frame holds the grant indefinitely.

Decomposition:
- Package noc_pkg:
  - PKT_W=13, PAYLOAD_W=8.
  - Enum pkt_type_e {PKT_DATA=2'b00, PKT_CTRL=2'b01, PKT_RESP=2'b10}.
  - Field-position localparams TYPE_MSB/LSB, EOF_BIT, SEQ_MSB/LSB.
  - FSM enum pz_state_e {PZ_IDLE, PZ_BURST}.
- Sub-module noc_rr_arbiter:
  - 3-request round-robin.
  - Pointer advances only on an `advance` strobe.
  - One-hot grant output.

Test Plan:
- Data-only frame: bytes 0x11, 0x22, 0x33 (last on 0x33), src_ready=1 → packets 0x0011, 0x0022, 0x0433 on consecutive cycles; the next data frame carries seq=1 (0x0111…).
- ctrl and resp both valid, single-beat frames 0xA5 and 0x5A → ctrl 0x0CA5 first, then resp 0x145A after one bubble cycle.
- Back-pressure: src_ready=0 for 5 cycles mid-frame → packet stable, ctrl_in_ready=0, no beat lost or duplicated.
- Interleave check: resp valid while a data frame is in progress → no resp packet until the data eof packet is accepted.
- Reset asserted mid-frame → src_valid=0 immediately; after release the seq counters restart at 0 and the RR pointer at data.
- With NOC_PKT_TIMEOUT_EN and TIMEOUT_CYCLES=4: the data channel stops after beat 0x10 → 4 cycles later packet 0x04FF is sent, err_timeout pulses once, and the FSM returns to IDLE.
